game_state_ctrl: RTL and testbench

Frame-synchronous game-state controller that sequences the pixel colour stage. Debounces the pause and start keys, tracks remaining lives, and runs the IDLE/PLAY/PAUSED/OVER state machine. Drives the `Pause` and `endGame` overlay controls consumed by `color_mapper`, plus the `run` enable for the game/physics logic. All overlay changes commit only at frame boundaries, so an overlay never tears mid-frame.

---
 rtl/game_pkg.sv | 20 ++
 rtl/game_state_ctrl_if.sv | 30 +++
 rtl/key_debounce.sv | 48 ++++
 rtl/game_state_ctrl.sv | 147 ++++++++++++++
 tb/tb_game_state_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and default constants for the game-state controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } game_state_t;

  typedef logic [1:0] lives_t;

  localparam int DEF_DEBOUNCE_CYCLES  = 250000;
  localparam int DEF_START_LIVES      = 3;
  localparam int DEF_BLINK_FRAMES     = 30;
  localparam int DEF_OVER_HOLD_FRAMES = 120;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the game environment and the state controller.
// Latency: n/a (wiring only).
// Backpressure: none; frame_start and ball_lost are single-cycle pulses.
// Ports: frame_start, key_pause, key_start, ball_lost toward the controller;
//        Pause, endGame, run, lives back from it.
interface game_state_ctrl_if;
  import game_pkg::*;

  logic   frame_start;
  logic   key_pause;
  logic   key_start;
  logic   ball_lost;
  logic   Pause;
  logic   endGame;
  logic   run;
  lives_t lives;

  // environment / game-logic side
  modport master (
    output frame_start, key_pause, key_start, ball_lost,
    input  Pause, endGame, run, lives
  );

  // controller side
  modport slave (
    input  frame_start, key_pause, key_start, ball_lost,
    output Pause, endGame, run, lives
  );

endinterface

// File: rtl/key_debounce.sv
// Key conditioner: 2-flop synchronizer, debounce counter, rising-edge press pulse.
// Latency: raw edge -> press pulse = 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; press is a one-cycle pulse.
// Ports: Clk, Reset (sync, active-high), key (raw async level), press (pulse out).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = game_pkg::DEF_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], key};
      level_q <= level;
      press   <= level & ~level_q;
      // Count consecutive samples that disagree with the accepted level;
      // any agreeing sample (a bounce back) restarts the count.
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Frame-synchronous IDLE/PLAY/PAUSED/OVER controller driving overlay and run enables.
// Latency: outputs registered, change the cycle after the committing frame_start;
//          lives changes the cycle after ball_lost.
// Backpressure: none; key requests are held pending until the next frame_start.
// Ports: Clk, Reset (sync, active-high), bus (slave modport of game_state_ctrl_if).
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int START_LIVES      = DEF_START_LIVES,
  parameter int BLINK_FRAMES     = DEF_BLINK_FRAMES,
  parameter int OVER_HOLD_FRAMES = DEF_OVER_HOLD_FRAMES
) (
  input logic              Clk,
  input logic              Reset,
  game_state_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_PLAY   = 2'(PLAY);
  localparam logic [1:0] ST_PAUSED = 2'(PAUSED);
  localparam logic [1:0] ST_OVER   = 2'(OVER);

  localparam int BW = $clog2(2 * BLINK_FRAMES + 1);
  localparam int HW = $clog2(OVER_HOLD_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(OVER_HOLD_FRAMES);
  localparam lives_t        LIVES_INIT = lives_t'(START_LIVES);

  logic          press_pause, press_start;
  logic [1:0]    state, state_nx;
  lives_t        lives_q, lives_nx;
  logic [BW-1:0] blink_cnt, blink_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic          pend_pause, pend_pause_nx;
  logic          pend_start, pend_start_nx;
  logic          start_ok;
  logic          pause_q, pause_nx;
  logic          endgame_q, endgame_nx;
  logic          run_q, run_nx;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .Clk   (Clk),
    .Reset (Reset),
    .key   (bus.key_pause),
    .press (press_pause)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .Clk   (Clk),
    .Reset (Reset),
    .key   (bus.key_start),
    .press (press_start)
  );

  always_comb begin
    state_nx = state;
    lives_nx = lives_q;
    blink_nx = blink_cnt;
    hold_nx  = hold_cnt;

    case (state)
      ST_IDLE: begin
        if (bus.frame_start && pend_start) begin
          lives_nx = LIVES_INIT;
          state_nx = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.ball_lost && (lives_q != '0))
          lives_nx = lives_q - 1'b1;
        if (bus.frame_start) begin
          if (lives_q == '0) begin
            state_nx = ST_OVER;
            hold_nx  = '0;
          end else if (pend_pause && (lives_nx != '0)) begin
            // a ball lost on this very cycle that empties lives blocks the
            // pause; OVER is taken at the following frame instead
            state_nx = ST_PAUSED;
            blink_nx = '0;
          end
        end
      end
      ST_PAUSED: begin
        if (bus.frame_start) begin
          if (pend_pause)
            state_nx = ST_PLAY;
          else
            blink_nx = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        end
      end
      default: begin  // ST_OVER
        if (bus.frame_start) begin
          if ((hold_cnt == HOLD_MAX) && pend_start) begin
            lives_nx = LIVES_INIT;
            state_nx = ST_PLAY;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_nx = hold_cnt + 1'b1;
          end
        end
      end
    endcase

    // Start presses during the OVER hold-off are dropped on arrival.
    start_ok = !((state_nx == ST_OVER) && (hold_nx != HOLD_MAX));

    // frame_start consumes the flags; a press on that same cycle is kept
    // fresh so it is examined at the following frame.
    pend_pause_nx = bus.frame_start ? press_pause : (pend_pause | press_pause);
    pend_start_nx = (bus.frame_start ? press_start : (pend_start | press_start)) & start_ok;

    run_nx     = (state_nx == ST_PLAY) && (lives_nx != '0);
    pause_nx   = (state_nx == ST_PAUSED) && (blink_nx < BLINK_HALF);
    endgame_nx = (state_nx == ST_OVER);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      lives_q    <= LIVES_INIT;
      blink_cnt  <= '0;
      hold_cnt   <= '0;
      pend_pause <= 1'b0;
      pend_start <= 1'b0;
      pause_q    <= 1'b0;
      endgame_q  <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      lives_q    <= lives_nx;
      blink_cnt  <= blink_nx;
      hold_cnt   <= hold_nx;
      pend_pause <= pend_pause_nx;
      pend_start <= pend_start_nx;
      pause_q    <= pause_nx;
      endgame_q  <= endgame_nx;
      run_q      <= run_nx;
    end
  end

  assign bus.Pause   = pause_q;
  assign bus.endGame = endgame_q;
  assign bus.run     = run_q;
  assign bus.lives   = lives_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Testbench for game_state_ctrl: scoreboard of expected {Pause,endGame,run,lives}.
// Latency: n/a.
// Backpressure: n/a.
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int DB = 4;
  localparam int SL = 3;
  localparam int BF = 2;
  localparam int OH = 3;
  localparam int FP = 20;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  game_state_ctrl_if gif();

  game_state_ctrl #(
    .DEBOUNCE_CYCLES  (DB),
    .START_LIVES      (SL),
    .BLINK_FRAMES     (BF),
    .OVER_HOLD_FRAMES (OH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (gif)
  );

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vec_cnt = 0;
  int  err_cnt = 0;
  int  cyc     = 0;

  function automatic logic [4:0] pk(input bit p, input bit e, input bit r, input logic [1:0] l);
    return {p, e, r, l};
  endfunction

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b want %b (Pause,endGame,run,lives[1:0])", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [4:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL sb_empty: got no expected entry at cycle %0d", cyc);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, {gif.Pause, gif.endGame, gif.run, gif.lives}, e.exp);
    end
  endtask

  // One clock: frame_start rides every FP-th cycle; inputs change on negedges.
  task automatic step();
    gif.frame_start = (cyc % FP == FP - 1);
    @(negedge Clk);
    cyc++;
    gif.frame_start = 1'b0;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Advance until just after the next committing frame_start.
  task automatic to_frame();
    bit f;
    do begin
      f = (cyc % FP == FP - 1);
      step();
    end while (!f);
  endtask

  task automatic press(input bit is_start);
    if (is_start) gif.key_start = 1'b1;
    else          gif.key_pause = 1'b1;
    steps(10);
    gif.key_start = 1'b0;
    gif.key_pause = 1'b0;
  endtask

  initial begin
    logic [7:0] blink_pat;
    blink_pat       = 8'b1100_1100;
    gif.frame_start = 1'b0;
    gif.key_pause   = 1'b0;
    gif.key_start   = 1'b0;
    gif.ball_lost   = 1'b0;
    Reset           = 1'b1;
    @(negedge Clk);

    // reset
    sb_push("reset", pk(0, 0, 0, 2'(SL)));
    steps(2);
    Reset = 1'b0;
    sb_check();

    // bouncing start key must not be accepted
    to_frame();
    sb_push("bounce_no_commit", pk(0, 0, 0, 3));
    for (int i = 0; i < 20; i++) begin
      gif.key_start = ((i / 2) % 2 == 0);
      step();
    end
    sb_check();
    sb_push("bounce_start", pk(0, 0, 1, 3));
    gif.key_start = 1'b1;
    steps(12);
    gif.key_start = 1'b0;
    to_frame();
    sb_check();

    // pause blink over eight frames, then resume
    for (int i = 0; i < 8; i++)
      sb_push($sformatf("blink_f%0d", i + 1), pk(blink_pat[7-i], 0, 0, 3));
    press(1'b0);
    to_frame();
    sb_check();
    for (int i = 1; i < 8; i++) begin
      to_frame();
      sb_check();
    end
    sb_push("resume", pk(0, 0, 1, 3));
    press(1'b0);
    to_frame();
    sb_check();

    // press pulse on the frame_start cycle commits one frame later
    sb_push("samecyc_hold", pk(0, 0, 1, 3));
    sb_push("samecyc_commit", pk(1, 0, 0, 3));
    steps(12);
    gif.key_pause = 1'b1;
    to_frame();
    sb_check();
    gif.key_pause = 1'b0;
    to_frame();
    sb_check();
    sb_push("samecyc_resume", pk(0, 0, 1, 3));
    press(1'b0);
    to_frame();
    sb_check();

    // three lost balls -> game over
    for (int i = 0; i < 3; i++) begin
      sb_push($sformatf("lost_%0d", i + 1), pk(0, 0, (i < 2), 2'(2 - i)));
      gif.ball_lost = 1'b1;
      step();
      gif.ball_lost = 1'b0;
      sb_check();
      step();
    end
    sb_push("over", pk(0, 1, 0, 0));
    to_frame();
    sb_check();

    // restart hold-off
    sb_push("hold_f1", pk(0, 1, 0, 0));
    press(1'b1);
    to_frame();
    sb_check();
    sb_push("hold_f2", pk(0, 1, 0, 0));
    to_frame();
    sb_check();
    sb_push("hold_f3", pk(0, 1, 0, 0));
    press(1'b1);
    to_frame();
    sb_check();
    sb_push("restart", pk(0, 0, 1, 3));
    press(1'b1);
    to_frame();
    sb_check();

    // last ball lost on the same cycle as a committing pause
    sb_push("coinc_lost1", pk(0, 0, 1, 2));
    sb_push("coinc_lost2", pk(0, 0, 1, 1));
    for (int i = 0; i < 2; i++) begin
      gif.ball_lost = 1'b1;
      step();
      gif.ball_lost = 1'b0;
      sb_check();
      step();
    end
    sb_push("coinc_no_pause", pk(0, 0, 0, 0));
    sb_push("coinc_over", pk(0, 1, 0, 0));
    press(1'b0);
    while (cyc % FP != FP - 1) step();
    gif.ball_lost = 1'b1;
    step();
    gif.ball_lost = 1'b0;
    sb_check();
    to_frame();
    sb_check();

    // reset mid-game, IDLE ignores pause, then start
    sb_push("mid_reset", pk(0, 0, 0, 3));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    sb_check();
    to_frame();
    sb_push("idle_pause_ignored", pk(0, 0, 0, 3));
    press(1'b0);
    to_frame();
    sb_check();
    sb_push("idle_start", pk(0, 0, 1, 3));
    press(1'b1);
    to_frame();
    sb_check();

    check_eq("sb_drain", 5'(sb_q.size()), 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
